// File: rtl/axil_arbiter_wr_if.sv
// Handshake and select bundle between the AXI-Lite write arbiter and its surroundings.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface axil_arbiter_wr_if #(
   parameter int NUMBER_MASTER = 2,
   parameter int NUMBER_SLAVE  = 4
);
   // Upstream masters
   logic [NUMBER_MASTER-1:0] req_awvalid;
   logic [NUMBER_MASTER-1:0] req_wvalid;
   logic [NUMBER_MASTER-1:0] req_bready;
   logic [NUMBER_MASTER-1:0] m_awready;
   logic [NUMBER_MASTER-1:0] m_wready;
   logic [NUMBER_MASTER-1:0] m_bvalid;
   logic [NUMBER_MASTER-1:0] grant_mst;

   // Address decoder and downstream slaves
   logic [NUMBER_SLAVE-1:0]  slv_valid;
   logic                     slv_invalid;
   logic [NUMBER_SLAVE-1:0]  s_awready;
   logic [NUMBER_SLAVE-1:0]  s_wready;
   logic [NUMBER_SLAVE-1:0]  s_bvalid;
   logic [NUMBER_SLAVE-1:0]  s_awvalid;
   logic [NUMBER_SLAVE-1:0]  s_wvalid;
   logic [NUMBER_SLAVE-1:0]  s_bready;
   logic [NUMBER_SLAVE-1:0]  grant_slv;
   logic                     decerr;

   modport slave (
      input  req_awvalid, req_wvalid, req_bready,
      input  slv_valid, slv_invalid,
      input  s_awready, s_wready, s_bvalid,
      output grant_mst, grant_slv,
      output m_awready, m_wready, m_bvalid,
      output s_awvalid, s_wvalid, s_bready,
      output decerr
   );

   modport master (
      output req_awvalid, req_wvalid, req_bready,
      output slv_valid, slv_invalid,
      output s_awready, s_wready, s_bvalid,
      input  grant_mst, grant_slv,
      input  m_awready, m_wready, m_bvalid,
      input  s_awvalid, s_wvalid, s_bready,
      input  decerr
   );
endinterface

// File: rtl/axil_arbiter_wr.sv
// AXI-Lite write-channel arbiter: grants one master at a time, routes AW/W/B handshakes to the
// decoded slave, answers decode misses with DECERR. Define AXIL_ARB_WR_RR_EN for round-robin.
module axil_arbiter_wr #(
   parameter int NUMBER_MASTER = 2,
   parameter int NUMBER_SLAVE  = 4
) (
   input  logic             aclk,
   input  logic             aresetn,
   axil_arbiter_wr_if.slave bus
);
   localparam int PW = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      ADDR,
      RESP,
      ERR_ACK,
      ERR_RESP
   } state_t;

   state_t                   state, state_nxt;
   logic [NUMBER_MASTER-1:0] grant_mst, grant_mst_nxt;
   logic [NUMBER_SLAVE-1:0]  grant_slv, grant_slv_nxt;
   logic                     aw_done, aw_done_nxt;
   logic                     w_done, w_done_nxt;

   logic [NUMBER_MASTER-1:0] req;
   logic [NUMBER_MASTER-1:0] win_oh;
   logic                     win_found;

   logic [NUMBER_MASTER-1:0] m_awready, m_wready, m_bvalid;
   logic [NUMBER_SLAVE-1:0]  s_awvalid, s_wvalid, s_bready;
   logic                     decerr;

   logic                     sel_awready, sel_wready, sel_bvalid, gnt_bready;

   // A master competes only once both its address and its data are on offer.
   assign req = bus.req_awvalid & bus.req_wvalid;

   // Collapse the per-port handshakes onto the current grant via the one-hot masks.
   assign sel_awready = |(bus.s_awready & grant_slv);
   assign sel_wready  = |(bus.s_wready  & grant_slv);
   assign sel_bvalid  = |(bus.s_bvalid  & grant_slv);
   assign gnt_bready  = |(bus.req_bready & grant_mst);

`ifdef AXIL_ARB_WR_RR_EN
   logic [PW-1:0] rr_ptr, rr_ptr_nxt;
   logic [PW-1:0] win_idx;
   logic [PW-1:0] cand;

   // rr_ptr holds the index where the next search begins (last winner + 1).
   always_comb begin
      win_oh    = '0;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUMBER_MASTER; k++) begin
         cand = PW'((int'(rr_ptr) + k) % NUMBER_MASTER);
         if (!win_found && req[cand]) begin
            win_found    = 1'b1;
            win_oh[cand] = 1'b1;
            win_idx      = cand;
         end
      end
   end

   assign rr_ptr_nxt = (win_idx == PW'(NUMBER_MASTER - 1)) ? '0 : win_idx + PW'(1);

   always_ff @(posedge aclk) begin
      if (!aresetn)
         rr_ptr <= '0;
      else if (state == IDLE && win_found)
         rr_ptr <= rr_ptr_nxt;
   end
`else
   always_comb begin
      win_oh    = '0;
      win_found = 1'b0;
      for (int k = 0; k < NUMBER_MASTER; k++) begin
         if (!win_found && req[k]) begin
            win_found = 1'b1;
            win_oh[k] = 1'b1;
         end
      end
   end
`endif

   // NOTE: state registers use non-blocking assignments; every register, including the grant
   // vectors, is cleared by the synchronous reset since the bus depends on all of them.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state     <= IDLE;
         grant_mst <= '0;
         grant_slv <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         state     <= state_nxt;
         grant_mst <= grant_mst_nxt;
         grant_slv <= grant_slv_nxt;
         aw_done   <= aw_done_nxt;
         w_done    <= w_done_nxt;
      end
   end

   // NOTE: every signal written here gets a default first, so no branch can infer a latch.
   always_comb begin
      state_nxt     = state;
      grant_mst_nxt = grant_mst;
      grant_slv_nxt = grant_slv;
      aw_done_nxt   = aw_done;
      w_done_nxt    = w_done;
      m_awready     = '0;
      m_wready      = '0;
      m_bvalid      = '0;
      s_awvalid     = '0;
      s_wvalid      = '0;
      s_bready      = '0;
      decerr        = 1'b0;

      case (state)
         IDLE: begin
            if (win_found) begin
               grant_mst_nxt = win_oh;
               state_nxt     = DECODE;
            end
         end

         DECODE: begin
            if (|bus.slv_valid) begin
               grant_slv_nxt = bus.slv_valid;
               state_nxt     = ADDR;
            end else if (bus.slv_invalid) begin
               state_nxt = ERR_ACK;
            end
         end

         ADDR: begin
            s_awvalid   = grant_slv & {NUMBER_SLAVE{!aw_done}};
            s_wvalid    = grant_slv & {NUMBER_SLAVE{!w_done}};
            m_awready   = grant_mst & {NUMBER_MASTER{sel_awready && !aw_done}};
            m_wready    = grant_mst & {NUMBER_MASTER{sel_wready && !w_done}};
            // AW and W complete independently and may both land in the same cycle.
            aw_done_nxt = aw_done | (sel_awready & !aw_done);
            w_done_nxt  = w_done  | (sel_wready  & !w_done);
            if (aw_done_nxt && w_done_nxt)
               state_nxt = RESP;
         end

         RESP: begin
            s_bready = grant_slv & {NUMBER_SLAVE{gnt_bready}};
            m_bvalid = grant_mst & {NUMBER_MASTER{sel_bvalid}};
            if (sel_bvalid && gnt_bready) begin
               grant_mst_nxt = '0;
               grant_slv_nxt = '0;
               aw_done_nxt   = 1'b0;
               w_done_nxt    = 1'b0;
               state_nxt     = IDLE;
            end
         end

         ERR_ACK: begin
            // Swallow the unroutable address and data in a single beat.
            m_awready = grant_mst;
            m_wready  = grant_mst;
            state_nxt = ERR_RESP;
         end

         ERR_RESP: begin
            m_bvalid = grant_mst;
            decerr   = 1'b1;
            if (gnt_bready) begin
               grant_mst_nxt = '0;
               state_nxt     = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase

      // Handshakes go quiet as soon as reset is asserted, not one edge later.
      if (!aresetn) begin
         m_awready = '0;
         m_wready  = '0;
         m_bvalid  = '0;
         s_awvalid = '0;
         s_wvalid  = '0;
         s_bready  = '0;
         decerr    = 1'b0;
      end
   end

   assign bus.grant_mst = grant_mst;
   assign bus.grant_slv = grant_slv;
   assign bus.m_awready = m_awready;
   assign bus.m_wready  = m_wready;
   assign bus.m_bvalid  = m_bvalid;
   assign bus.s_awvalid = s_awvalid;
   assign bus.s_wvalid  = s_wvalid;
   assign bus.s_bready  = s_bready;
   assign bus.decerr    = decerr;
endmodule

// File: tb/tb_axil_arbiter_wr.sv
// Directed bench for axil_arbiter_wr: single write, priority, back-to-back grants, decode
// error path and mid-transaction reset, with hand-computed expectations.
module tb_axil_arbiter_wr;
   localparam int NM = 2;
   localparam int NS = 4;
`ifdef AXIL_ARB_WR_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   int   n_cmp   = 0;
   int   n_err   = 0;

   axil_arbiter_wr_if #(.NUMBER_MASTER(NM), .NUMBER_SLAVE(NS)) bus ();

   axil_arbiter_wr #(.NUMBER_MASTER(NM), .NUMBER_SLAVE(NS)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow after a further settle.
   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_awvalid = '0;
      bus.req_wvalid  = '0;
      bus.req_bready  = '0;
      bus.slv_valid   = '0;
      bus.slv_invalid = 1'b0;
      bus.s_awready   = '0;
      bus.s_wready    = '0;
      bus.s_bvalid    = '0;
   endtask

   // One write with AWREADY and WREADY together; starts and ends with the arbiter in IDLE.
   task automatic do_write(input string tag, input logic [1:0] req, input logic [3:0] slv,
                           input logic [1:0] gnt, input bit drop);
      bus.req_awvalid = req;
      bus.req_wvalid  = req;
      bus.slv_valid   = slv;
      step();
      check({tag, "_grant_mst"}, 32'(bus.grant_mst), 32'(gnt));
      step();
      bus.slv_valid = '0;
      check({tag, "_grant_slv"}, 32'(bus.grant_slv), 32'(slv));
      bus.s_awready = slv;
      bus.s_wready  = slv;
      #1;
      check({tag, "_m_awready"}, 32'(bus.m_awready), 32'(gnt));
      check({tag, "_m_wready"}, 32'(bus.m_wready), 32'(gnt));
      step();
      bus.s_awready = '0;
      bus.s_wready  = '0;
      if (drop) begin
         bus.req_awvalid = req & ~gnt;
         bus.req_wvalid  = req & ~gnt;
      end
      bus.s_bvalid   = slv;
      bus.req_bready = gnt;
      #1;
      check({tag, "_m_bvalid"}, 32'(bus.m_bvalid), 32'(gnt));
      check({tag, "_s_bready"}, 32'(bus.s_bready), 32'(slv));
      step();
      bus.s_bvalid   = '0;
      bus.req_bready = '0;
      #1;
      check({tag, "_idle_grant"}, 32'(bus.grant_mst), 32'h0);
   endtask

   initial begin
      clear_inputs();

      // Reset state
      aresetn = 1'b0;
      step();
      step();
      check("rst_grant_mst", 32'(bus.grant_mst), 32'h0);
      check("rst_grant_slv", 32'(bus.grant_slv), 32'h0);
      check("rst_m_awready", 32'(bus.m_awready), 32'h0);
      check("rst_decerr", 32'(bus.decerr), 32'h0);
      aresetn = 1'b1;

      // Master 0 -> slave 2, AWREADY one cycle ahead of WREADY
      bus.req_awvalid = 2'b01;
      bus.req_wvalid  = 2'b01;
      bus.slv_valid   = 4'b0100;
      step();
      check("w1_grant_mst", 32'(bus.grant_mst), 32'h1);
      step();
      check("w1_grant_slv", 32'(bus.grant_slv), 32'h4);
      check("w1_s_awvalid", 32'(bus.s_awvalid), 32'h4);
      check("w1_s_wvalid", 32'(bus.s_wvalid), 32'h4);
      check("w1_m_awready_wait", 32'(bus.m_awready), 32'h0);
      bus.s_awready = 4'b0100;
      #1;
      check("w1_m_awready", 32'(bus.m_awready), 32'h1);
      check("w1_m_wready_wait", 32'(bus.m_wready), 32'h0);
      step();
      bus.s_awready = '0;
      bus.s_wready  = 4'b0100;
      #1;
      check("w1_s_awvalid_done", 32'(bus.s_awvalid), 32'h0);
      check("w1_m_awready_once", 32'(bus.m_awready), 32'h0);
      check("w1_m_wready", 32'(bus.m_wready), 32'h1);
      step();
      bus.s_wready    = '0;
      bus.req_awvalid = '0;
      bus.req_wvalid  = '0;
      bus.s_bvalid    = 4'b0100;
      #1;
      check("w1_m_wready_once", 32'(bus.m_wready), 32'h0);
      check("w1_m_bvalid", 32'(bus.m_bvalid), 32'h1);
      check("w1_s_bready_wait", 32'(bus.s_bready), 32'h0);
      bus.req_bready = 2'b01;
      #1;
      check("w1_s_bready", 32'(bus.s_bready), 32'h4);
      step();
      bus.s_bvalid   = '0;
      bus.req_bready = '0;
      #1;
      check("w1_idle_grant_mst", 32'(bus.grant_mst), 32'h0);
      check("w1_idle_grant_slv", 32'(bus.grant_slv), 32'h0);
      check("w1_idle_m_bvalid", 32'(bus.m_bvalid), 32'h0);

      // Simultaneous requests after a fresh reset; each master drops after completion
      aresetn = 1'b0;
      step();
      aresetn = 1'b1;
      do_write("pri_a", 2'b11, 4'b0001, 2'b01, 1'b1);
      do_write("pri_b", 2'b10, 4'b0010, 2'b10, 1'b1);

      // Both masters request continuously
      for (int i = 0; i < 4; i++) begin
         logic [1:0] exp_gnt;
         exp_gnt = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
         do_write($sformatf("cont%0d", i), 2'b11, 4'b1000, exp_gnt, 1'b0);
      end
      clear_inputs();
      step();

      // Decode miss: one stall cycle in DECODE, then DECERR path
      bus.req_awvalid = 2'b01;
      bus.req_wvalid  = 2'b01;
      step();
      check("err_grant_mst", 32'(bus.grant_mst), 32'h1);
      step();
      check("err_decode_stall", 32'(bus.m_awready), 32'h0);
      bus.slv_invalid = 1'b1;
      step();
      bus.slv_invalid = 1'b0;
      #1;
      check("err_m_awready", 32'(bus.m_awready), 32'h1);
      check("err_m_wready", 32'(bus.m_wready), 32'h1);
      check("err_s_awvalid", 32'(bus.s_awvalid), 32'h0);
      check("err_s_wvalid", 32'(bus.s_wvalid), 32'h0);
      check("err_ack_decerr", 32'(bus.decerr), 32'h0);
      step();
      bus.req_awvalid = '0;
      bus.req_wvalid  = '0;
      #1;
      check("err_m_awready_once", 32'(bus.m_awready), 32'h0);
      check("err_m_bvalid", 32'(bus.m_bvalid), 32'h1);
      check("err_decerr", 32'(bus.decerr), 32'h1);
      step();
      check("err_hold_m_bvalid", 32'(bus.m_bvalid), 32'h1);
      check("err_hold_decerr", 32'(bus.decerr), 32'h1);
      check("err_s_bready", 32'(bus.s_bready), 32'h0);
      check("err_grant_slv", 32'(bus.grant_slv), 32'h0);
      bus.req_bready = 2'b01;
      step();
      bus.req_bready = '0;
      #1;
      check("err_done_decerr", 32'(bus.decerr), 32'h0);
      check("err_done_m_bvalid", 32'(bus.m_bvalid), 32'h0);
      check("err_done_grant", 32'(bus.grant_mst), 32'h0);

      // Reset while in RESP with the slave's BVALID up
      bus.req_awvalid = 2'b01;
      bus.req_wvalid  = 2'b01;
      bus.slv_valid   = 4'b0100;
      step();
      step();
      bus.slv_valid = '0;
      bus.s_awready = 4'b0100;
      bus.s_wready  = 4'b0100;
      step();
      bus.s_awready   = '0;
      bus.s_wready    = '0;
      bus.req_awvalid = '0;
      bus.req_wvalid  = '0;
      bus.s_bvalid    = 4'b0100;
      #1;
      check("rr_resp_m_bvalid", 32'(bus.m_bvalid), 32'h1);
      aresetn = 1'b0;
      #1;
      check("rr_async_m_bvalid", 32'(bus.m_bvalid), 32'h0);
      step();
      check("rr_grant_mst", 32'(bus.grant_mst), 32'h0);
      check("rr_grant_slv", 32'(bus.grant_slv), 32'h0);
      check("rr_m_bvalid", 32'(bus.m_bvalid), 32'h0);
      check("rr_s_bready", 32'(bus.s_bready), 32'h0);
      aresetn         = 1'b1;
      bus.s_bvalid    = '0;
      bus.req_awvalid = 2'b11;
      bus.req_wvalid  = 2'b11;
      step();
      check("rr_regrant", 32'(bus.grant_mst), 32'h1);

      clear_inputs();
      aresetn = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
